sweep_ctrl: RTL and testbench

//  Frequency-sweep sequencer for the sine generator datapath (address counter + sine ROM).

---
 rtl/sweep_pkg.sv | 16 +
 rtl/dwell_timer.sv | 28 ++
 rtl/sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sweep_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and default widths for the frequency-sweep sequencer.
// The TURN state exists only when SWEEP_BIDIR_EN is defined.
package sweep_pkg;

    localparam int SWEEP_D_WIDTH     = 8;
    localparam int SWEEP_DWELL_WIDTH = 16;

`ifdef SWEEP_BIDIR_EN
    typedef enum logic [1:0] {IDLE, RUN, TURN, DONE} sweep_state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;
`endif

    typedef enum logic {UP, DOWN} dir_t;

endpackage

// File: rtl/dwell_timer.sv
// Down-counting dwell timer: load starts a hold of max(value,1) cycles and
// o_expire is high during the last cycle of that hold.
module dwell_timer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic                   i_clear,
    input  logic [DWELL_WIDTH-1:0] i_value,
    output logic                   o_expire
);

    logic [DWELL_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_value == '0) ? DWELL_WIDTH'(1) : i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - DWELL_WIDTH'(1);
        end
    end

    assign o_expire = (r_cnt == DWELL_WIDTH'(1));

endmodule

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer driving the sine generator's phase increment and enable.
// Define SWEEP_BIDIR_EN to sweep back to f_start after reaching f_stop (TURN state).
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int D_WIDTH     = SWEEP_D_WIDTH,
    parameter int DWELL_WIDTH = SWEEP_DWELL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [D_WIDTH-1:0]     f_start,
    input  logic [D_WIDTH-1:0]     f_stop,
    input  logic [D_WIDTH-1:0]     f_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [D_WIDTH-1:0]     incr,
    output logic                   en,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             dbg_state
);

    sweep_state_t           r_state;
    dir_t                   r_dir;
    logic [D_WIDTH-1:0]     r_incr;
    logic [D_WIDTH-1:0]     r_target;
    logic [D_WIDTH-1:0]     r_step;
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic                   r_en;
    logic                   r_busy;
    logic                   r_done;
`ifdef SWEEP_BIDIR_EN
    logic [D_WIDTH-1:0]     r_f_start;
    logic                   w_turn;
`endif

    logic [D_WIDTH:0]       w_sum;
    logic [D_WIDTH:0]       w_diff;
    logic [D_WIDTH-1:0]     w_next;
    logic                   w_leg_end;
    logic                   w_expire;
    logic                   w_load;
    logic                   w_clear;
    logic [DWELL_WIDTH-1:0] w_load_val;

    // One step toward the target in D_WIDTH+1 bits so a carry or borrow clamps instead of wrapping.
    always_comb begin
        w_sum  = {1'b0, r_incr} + {1'b0, r_step};
        w_diff = {1'b0, r_incr} - {1'b0, r_step};
        w_next = r_target;
        if (r_dir == UP) begin
            if (w_sum < {1'b0, r_target}) w_next = w_sum[D_WIDTH-1:0];
        end else begin
            if (!w_diff[D_WIDTH] && (w_diff[D_WIDTH-1:0] > r_target)) w_next = w_diff[D_WIDTH-1:0];
        end
    end

    assign w_leg_end = (r_incr == r_target) || (r_step == '0);
`ifdef SWEEP_BIDIR_EN
    assign w_turn = w_leg_end && (r_step != '0) && (r_target != r_f_start);
`endif

    always_comb begin
        w_load     = 1'b0;
        w_clear    = abort && (r_state != IDLE);
        w_load_val = (r_state == IDLE) ? dwell : r_dwell;
        if (!abort) begin
            if (r_state == IDLE && start) w_load = 1'b1;
            if (r_state == RUN && w_expire && !w_leg_end) w_load = 1'b1;
`ifdef SWEEP_BIDIR_EN
            if (r_state == TURN) w_load = 1'b1;
`endif
        end
    end

    dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_clear  (w_clear),
        .i_value  (w_load_val),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_dir    <= UP;
            r_incr   <= '0;
            r_target <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            r_f_start <= '0;
`endif
        end else if (r_state != IDLE && abort) begin
            r_state <= IDLE;
            r_incr  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_state  <= RUN;
                        r_dir    <= (f_stop < f_start) ? DOWN : UP;
                        r_incr   <= f_start;
                        r_target <= f_stop;
                        r_step   <= f_step;
                        r_dwell  <= dwell;
                        r_en     <= 1'b1;
                        r_busy   <= 1'b1;
`ifdef SWEEP_BIDIR_EN
                        r_f_start <= f_start;
`endif
                    end
                end
                RUN: begin
                    if (w_expire) begin
                        if (!w_leg_end) begin
                            r_incr <= w_next;
`ifdef SWEEP_BIDIR_EN
                        end else if (w_turn) begin
                            r_state  <= TURN;
                            r_dir    <= (r_dir == UP) ? DOWN : UP;
                            r_target <= r_f_start;
`endif
                        end else begin
                            r_state <= DONE;
                            r_en    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
`ifdef SWEEP_BIDIR_EN
                TURN: begin
                    // f_stop already dwelled once, so the return leg starts one step away from it.
                    r_state <= RUN;
                    r_incr  <= w_next;
                end
`endif
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign incr      = r_incr;
    assign en        = r_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: table of sweep configs with expected increment
// sequences, expanded into a per-cycle expected queue, plus abort/reset/start corner cases.
module tb_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  f_start;
    logic [7:0]  f_stop;
    logic [7:0]  f_step;
    logic [15:0] dwell;
    logic [7:0]  incr;
    logic        en;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    typedef struct {
        logic [7:0]  fs;
        logic [7:0]  fe;
        logic [7:0]  st;
        logic [15:0] dw;
        int          n;
        int          turn;
        logic [63:0] seq;
    } sweep_vec_t;

    sweep_vec_t  vecs[$];
    logic [10:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    sweep_ctrl #(.D_WIDTH(8), .DWELL_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .incr      (incr),
        .en        (en),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {done,busy,en,incr}=%h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] fs, input logic [7:0] fe, input logic [7:0] st,
                           input logic [15:0] dw, input int n, input int turn, input logic [63:0] seq);
        sweep_vec_t v;
        v.fs = fs; v.fe = fe; v.st = st; v.dw = dw; v.n = n; v.turn = turn; v.seq = seq;
        vecs.push_back(v);
    endtask

    task automatic push_expect(input sweep_vec_t v);
        int         reps;
        logic [7:0] val;
        logic [7:0] last;
        last = 8'd0;
        for (int i = 0; i < v.n; i++) begin
            val  = v.seq[63-8*i -: 8];
            reps = (i == v.turn || v.dw == 16'd0) ? 1 : int'(v.dw);
            for (int r = 0; r < reps; r++) exp_q.push_back({3'b011, val});
            last = val;
        end
        exp_q.push_back({3'b100, last});
    endtask

    task automatic run_vec(input sweep_vec_t v, input string name, input int inject_at,
                           input int kill_at, input bit kill_rst);
        int          cyc;
        logic [10:0] e;
        cyc = 0;
        @(negedge clk);
        f_start = v.fs; f_stop = v.fe; f_step = v.st; dwell = v.dw;
        start = 1'b1;
        push_expect(v);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("%s/cyc%0d", name, cyc), {5'd0, done, busy, en, incr}, {5'd0, e});
            if (cyc == inject_at) begin
                start = 1'b1;
                f_start = 8'd100; f_stop = 8'd3; f_step = 8'd1; dwell = 16'd7;
            end
            if (cyc == kill_at) begin
                if (kill_rst) rst = 1'b1;
                else abort = 1'b1;
                exp_q.delete();
                exp_q.push_back(11'h0);
            end
        end
        start = 1'b0;
        repeat ((kill_at > 0) ? 12 : 2) begin
            @(negedge clk);
            check({name, "/idle"}, {13'd0, done, busy, en}, 16'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = 8'd0; f_stop = 8'd0; f_step = 8'd0; dwell = 16'd0;
        repeat (2) @(negedge clk);
        check("reset", {5'd0, done, busy, en, incr}, 16'd0);
        rst = 1'b0;

        // start and abort together in IDLE: abort wins, nothing starts
        @(negedge clk);
        f_start = 8'd4; f_stop = 8'd16; f_step = 8'd4; dwell = 16'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {5'd0, done, busy, en, incr}, 16'd0);
        @(negedge clk);
        check("start_abort_idle2", {5'd0, done, busy, en, incr}, 16'd0);

`ifdef SWEEP_BIDIR_EN
        add_vec(8'd4,   8'd16, 8'd4,   16'd3, 8, 4, {8'd4, 8'd8, 8'd12, 8'd16, 8'd16, 8'd12, 8'd8, 8'd4});
        add_vec(8'd20,  8'd5,  8'd7,   16'd2, 8, 4, {8'd20, 8'd13, 8'd6, 8'd5, 8'd5, 8'd12, 8'd19, 8'd20});
        add_vec(8'd250, 8'd255, 8'd10, 16'd0, 4, 2, {8'd250, 8'd255, 8'd255, 8'd250, 32'd0});
        add_vec(8'd9,   8'd9,  8'd3,   16'd2, 1, -1, {8'd9, 56'd0});
        add_vec(8'd0,   8'd255, 8'd100, 16'd1, 8, 4, {8'd0, 8'd100, 8'd200, 8'd255, 8'd255, 8'd155, 8'd55, 8'd0});
        add_vec(8'd255, 8'd0,  8'd128, 16'd1, 6, 3, {8'd255, 8'd127, 8'd0, 8'd0, 8'd128, 8'd255, 16'd0});
        add_vec(8'd4,   8'd12, 8'd4,   16'd1, 6, 3, {8'd4, 8'd8, 8'd12, 8'd12, 8'd8, 8'd4, 16'd0});
`else
        add_vec(8'd4,   8'd16, 8'd4,   16'd3, 4, -1, {8'd4, 8'd8, 8'd12, 8'd16, 32'd0});
        add_vec(8'd20,  8'd5,  8'd7,   16'd2, 4, -1, {8'd20, 8'd13, 8'd6, 8'd5, 32'd0});
        add_vec(8'd250, 8'd255, 8'd10, 16'd0, 2, -1, {8'd250, 8'd255, 48'd0});
        add_vec(8'd9,   8'd9,  8'd3,   16'd2, 1, -1, {8'd9, 56'd0});
        add_vec(8'd0,   8'd255, 8'd100, 16'd1, 4, -1, {8'd0, 8'd100, 8'd200, 8'd255, 32'd0});
        add_vec(8'd255, 8'd0,  8'd128, 16'd1, 3, -1, {8'd255, 8'd127, 8'd0, 40'd0});
        add_vec(8'd4,   8'd12, 8'd4,   16'd1, 3, -1, {8'd4, 8'd8, 8'd12, 40'd0});
`endif
        add_vec(8'd7, 8'd30, 8'd0, 16'd1, 1, -1, {8'd7, 56'd0});

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i), 0, 0, 1'b0);

        // start with a different config while busy: sweep must be unaffected
        run_vec(vecs[0], "busy_start", 2, 0, 1'b0);
        // abort during the second dwell cycle of incr=8: no done pulse afterwards
        run_vec(vecs[0], "abort", 0, 5, 1'b0);
        // synchronous reset mid-sweep, then a normal sweep from clean state
        run_vec(vecs[0], "mid_rst", 0, 4, 1'b1);
        run_vec(vecs[1], "after_rst", 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
